// File: rtl/hm_codec_arbiter.sv
// Round-robin arbiter sharing one Hamming(7,4) encoder/decoder between requesters A and B; optional corrected-word counter under HM_ARB_ERRCNT_EN.
// Latency: 1 cycle from accept to out_valid, with a throughput of 1 result per cycle.
// Backpressure: a single result slot; a request is granted only when the slot is empty or is being drained this cycle.

module hm_enc (
  input  logic [3:0] info,
  output logic [6:0] code
);
  // Data occupies codeword positions 3,5,6,7; parity occupies positions 1,2,4.
  always_comb begin
    code    = '0;
    code[2] = info[0];
    code[4] = info[1];
    code[5] = info[2];
    code[6] = info[3];
    code[0] = info[0] ^ info[1] ^ info[3];
    code[1] = info[0] ^ info[2] ^ info[3];
    code[3] = info[1] ^ info[2] ^ info[3];
  end
endmodule

module hm_dec (
  input  logic [6:0] code,
  output logic [3:0] info,
  output logic [2:0] syn
);
  logic [6:0] flip;
  logic [6:0] fixed;

  always_comb begin
    syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
    syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
    syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
    flip   = '0;
    if (syn != 3'd0) flip[syn - 3'd1] = 1'b1;
    fixed  = code ^ flip;
    // The info word is returned with r2 as its MSB.
    info   = {fixed[2], fixed[4], fixed[5], fixed[6]};
  end
endmodule

module hm_codec_arbiter #(
  parameter int CNT_W   = 8,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic             a_op,
  input  logic [6:0]       a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic             b_op,
  input  logic [6:0]       b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [6:0]       out_data,
  output logic             out_id,
  output logic             out_op,
  output logic             out_corr,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);
  typedef enum logic {EMPTY, FULL} slot_state_t;

  typedef struct packed {
    logic [6:0] data;
    logic       id;
    logic       op;
    logic       corr;
  } result_t;

  slot_state_t state, state_nxt;
  result_t     res_q, res_nxt;
  logic        pref_b;
  logic        free, grant_a, grant_b, grant;
  logic        sel_op;
  logic [6:0]  sel_data;
  logic [6:0]  enc_code;
  logic [3:0]  dec_info;
  logic [2:0]  dec_syn;

  always_comb begin
    state_nxt = state;
    free      = (state == EMPTY) || out_ready;
    grant_a   = rst_n && free && a_valid && (!b_valid || !pref_b);
    grant_b   = rst_n && free && b_valid && (!a_valid || pref_b);
    grant     = grant_a || grant_b;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (out_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       pref_b <= (RR_INIT != 0);
    else if (grant_a) pref_b <= 1'b1;
    else if (grant_b) pref_b <= 1'b0;
  end

  // The shared codec always sees the granted requester's payload.
  assign sel_op   = grant_b ? b_op   : a_op;
  assign sel_data = grant_b ? b_data : a_data;

  hm_enc u_enc (.info(sel_data[3:0]), .code(enc_code));
  hm_dec u_dec (.code(sel_data), .info(dec_info), .syn(dec_syn));

  always_comb begin
    res_nxt.id   = grant_b;
    res_nxt.op   = sel_op;
    res_nxt.data = sel_op ? enc_code : {3'b000, dec_info};
    res_nxt.corr = !sel_op && (dec_syn != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     res_q <= '0;
    else if (grant) res_q <= res_nxt;
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign out_valid = (state == FULL);
  assign out_data  = res_q.data;
  assign out_id    = res_q.id;
  assign out_op    = res_q.op;
  assign out_corr  = res_q.corr;

`ifdef HM_ARB_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Clear has priority; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr)
      cnt_q <= '0;
    else if (grant && res_nxt.corr && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign err_count = cnt_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif
endmodule

// File: tb/tb_hm_codec_arbiter.sv
// Scoreboard bench for hm_codec_arbiter: a stimulus process predicts grants and results; a monitor pops and compares on each output handshake.
module tb_hm_codec_arbiter;
  localparam int CNT_W   = 2;
  localparam int RR_INIT = 0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_valid, a_op, a_ready;
  logic [6:0]       a_data;
  logic             b_valid, b_op, b_ready;
  logic [6:0]       b_data;
  logic             out_valid, out_id, out_op, out_corr, out_ready;
  logic [6:0]       out_data;
  logic [CNT_W-1:0] err_count;
  logic             err_clr;

  always #5 clk = ~clk;

  hm_codec_arbiter #(.CNT_W(CNT_W), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_op(a_op), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_op(b_op), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_op(out_op),
    .out_corr(out_corr), .out_ready(out_ready),
    .err_count(err_count), .err_clr(err_clr)
  );

  typedef struct packed {
    logic [6:0] data;
    logic       id;
    logic       op;
    logic       corr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_full;
  bit   m_pref_b;
  int   m_cnt;
  bit   last_ga, last_gb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Syndrome as the XOR of the 1-based positions of all set bits.
  function automatic logic [2:0] ref_syn(input logic [6:0] r);
    logic [2:0] s = 3'd0;
    for (int p = 1; p <= 7; p++)
      if (r[p-1]) s = s ^ 3'(p);
    return s;
  endfunction

  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [6:0] w = '0;
    logic [2:0] s;
    w[2] = d[0]; w[4] = d[1]; w[5] = d[2]; w[6] = d[3];
    s = ref_syn(w);
    w[0] = s[0]; w[1] = s[1]; w[3] = s[2];
    return w;
  endfunction

  function automatic exp_t ref_result(input logic id, input logic op, input logic [6:0] d);
    exp_t e;
    logic [6:0] r = d;
    logic [2:0] s = ref_syn(d);
    e.id = id;
    e.op = op;
    if (op) begin
      e.data = ref_enc(d[3:0]);
      e.corr = 1'b0;
    end else begin
      if (s != 0) r[s-1] = ~r[s-1];
      e.data = {3'b000, r[2], r[4], r[5], r[6]};
      e.corr = (s != 0);
    end
    return e;
  endfunction

  // Called at posedge+1; drives one cycle, predicts and checks, returns at the next posedge+1.
  task automatic drive_cycle(input bit av, input bit aop, input logic [6:0] ad,
                             input bit bv, input bit bop, input logic [6:0] bd,
                             input bit ordy, input bit clr, input bit rst);
    bit   free, ga, gb;
    exp_t e;
    int   exp_cnt;
    a_valid = av; a_op = aop; a_data = ad;
    b_valid = bv; b_op = bop; b_data = bd;
    out_ready = ordy; err_clr = clr; rst_n = rst;
    #2;
    ga = 0; gb = 0;
    if (!rst) begin
      check("rst_a_ready", a_ready, 0);
      check("rst_b_ready", b_ready, 0);
      exp_q.delete();
      m_full = 0; m_pref_b = (RR_INIT != 0); m_cnt = 0;
    end else begin
`ifdef HM_ARB_ERRCNT_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = 0;
`endif
      check("out_valid", out_valid, 32'(m_full));
      check("err_count", err_count, exp_cnt);
      free = !m_full || ordy;
      if (free && av && bv) begin
        ga = !m_pref_b; gb = m_pref_b;
      end else begin
        ga = free && av; gb = free && bv;
      end
      check("a_ready", a_ready, 32'(ga));
      check("b_ready", b_ready, 32'(gb));
      if (ga || gb) begin
        e = ga ? ref_result(1'b0, aop, ad) : ref_result(1'b1, bop, bd);
        exp_q.push_back(e);
        m_pref_b = ga;
        m_full = 1;
        if (e.corr && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else if (ordy) begin
        m_full = 0;
      end
      if (clr) m_cnt = 0;
    end
    last_ga = ga; last_gb = gb;
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit ordy);
    drive_cycle(0, 0, 7'h00, 0, 0, 7'h00, ordy, 0, 1);
  endtask

  // Monitor: compares each handshaked result, and stability of a stalled slot.
  initial begin : monitor
    bit   hold_prev = 0;
    exp_t prev, got, e;
    forever begin
      @(negedge clk);
      got = {out_data, out_id, out_op, out_corr};
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (hold_prev) check("stall_stable", 32'(got), 32'(prev));
        if (out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(got), 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_id", out_id, e.id);
            check("out_op", out_op, e.op);
            check("out_corr", out_corr, e.corr);
          end
        end
      end
      hold_prev = (rst_n === 1'b1) && (out_valid === 1'b1) && (out_ready === 1'b0);
      prev = got;
    end
  end

  initial begin : stim
    bit         pa_v, pa_op, pb_v, pb_op;
    logic [6:0] pa_d, pb_d;
    a_valid = 0; a_op = 0; a_data = '0; b_valid = 0; b_op = 0; b_data = '0;
    out_ready = 0; err_clr = 0; rst_n = 0;
    @(posedge clk); #1;
    drive_cycle(1, 1, 7'h0B, 1, 0, 7'h55, 0, 0, 0);
    drive_cycle(0, 0, 7'h00, 0, 0, 7'h00, 0, 0, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_op", out_op, 0);
    check("rst_out_corr", out_corr, 0);

    // Encode from A, then decodes from B (clean and single-bit error).
    drive_cycle(1, 1, 7'h0B, 0, 0, 7'h00, 1, 0, 1);
    drive_cycle(0, 0, 7'h00, 1, 0, 7'h55, 1, 0, 1);
    drive_cycle(0, 0, 7'h00, 1, 0, 7'h54, 1, 0, 1);
    idle(1);

    // Both requesters valid: alternating grants.
    repeat (4) drive_cycle(1, 1, 7'h03, 1, 0, 7'h2A, 1, 0, 1);
    idle(1);

    // Backpressure then back-to-back drain.
    drive_cycle(1, 1, 7'h05, 0, 0, 7'h00, 0, 0, 1);
    repeat (3) drive_cycle(1, 0, 7'h33, 1, 1, 7'h0E, 0, 0, 1);
    drive_cycle(1, 0, 7'h33, 1, 1, 7'h0E, 1, 0, 1);
    drive_cycle(0, 0, 7'h00, 1, 1, 7'h0E, 1, 0, 1);
    idle(1);

    // Counter saturation and clear priority.
    repeat (5) drive_cycle(1, 0, 7'h54, 0, 0, 7'h00, 1, 0, 1);
    drive_cycle(1, 0, 7'h54, 0, 0, 7'h00, 1, 1, 1);
    idle(1);
    idle(1);

    // Reset while full and stalled.
    drive_cycle(0, 0, 7'h00, 1, 1, 7'h09, 0, 0, 1);
    drive_cycle(1, 0, 7'h54, 0, 0, 7'h00, 0, 0, 1);
    drive_cycle(1, 1, 7'h01, 1, 1, 7'h02, 0, 0, 0);
    drive_cycle(1, 1, 7'h01, 1, 1, 7'h02, 1, 0, 1);
    idle(1);

    // Randomized traffic; requesters hold until accepted.
    pa_v = 0; pb_v = 0; pa_op = 0; pb_op = 0; pa_d = '0; pb_d = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!pa_v && $urandom_range(0, 2) != 0) begin
        pa_v = 1; pa_op = 1'($urandom); pa_d = 7'($urandom);
      end
      if (!pb_v && $urandom_range(0, 2) != 0) begin
        pb_v = 1; pb_op = 1'($urandom); pb_d = 7'($urandom);
      end
      drive_cycle(pa_v, pa_op, pa_d, pb_v, pb_op, pb_d,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 299) != 0);
      if (last_ga || rst_n == 1'b0) pa_v = 0;
      if (last_gb || rst_n == 1'b0) pb_v = 0;
    end

    repeat (4) idle(1);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
